// File: rtl/nonce_dispatch_ctrl_pkg.sv
// Shared types and defaults for the nonce dispatch controller: FSM state encoding,
// default job geometry and the batch-size helper used by the sequencer.
package nonce_dispatch_ctrl_pkg;

  localparam int DEF_NUM_NONCES = 16;
  localparam int DEF_NUM_CORES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Number of cores used by the batch that starts at nonce 'base'.
  function automatic logic [31:0] batch_size(input logic [31:0] base,
                                             input logic [31:0] num_nonces,
                                             input logic [31:0] num_cores);
    logic [31:0] remain;
    remain = (base < num_nonces) ? (num_nonces - base) : 32'd0;
    return (remain < num_cores) ? remain : num_cores;
  endfunction

endpackage

// File: rtl/nonce_dispatch_ctrl_core_result_latch.sv
// Per-core result holder: a sticky completion flag plus the H0 word captured
// on the most recent accepted completion pulse.
module core_result_latch (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [31:0] h0_in,
  output logic        flag,
  output logic [31:0] h0
);

  logic        flag_q, flag_d;
  logic [31:0] h0_q, h0_d;

  // NOTE: always_comb assigns every output a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    flag_d = flag_q;
    h0_d   = h0_q;
    if (clear) begin
      flag_d = 1'b0;
    end else if (capture) begin
      flag_d = 1'b1;
      h0_d   = h0_in;
    end
  end

  // NOTE: the captured H0 is a data register but is still reset, so no stale
  // hash from an abandoned job can ever reach the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= 1'b0;
      h0_q   <= '0;
    end else begin
      flag_q <= flag_d;
      h0_q   <= h0_d;
    end
  end

  assign flag = flag_q;
  assign h0   = h0_q;

endmodule

// File: rtl/nonce_dispatch_ctrl.sv
// Sequences a job of NUM_NONCES hashes over NUM_CORES SHA-256 cores in batches,
// collects each batch's H0 results and writes them to consecutive memory words.
module nonce_dispatch_ctrl
  import nonce_dispatch_ctrl_pkg::*;
#(
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int NUM_CORES  = DEF_NUM_CORES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic                    mem_clk,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                  state_q, state_d;
  logic [15:0]             base_q, base_d;
  logic [15:0]             addr_q, addr_d;
  logic [IW-1:0]           wr_idx_q, wr_idx_d;
  logic [NUM_CORES-1:0]    core_start_q, core_start_d;
  logic [NUM_CORES*32-1:0] core_nonce_q, core_nonce_d;

  logic [31:0]          batch_w, next_batch_w, next_base_w;
  logic [NUM_CORES-1:0] started_mask;
  logic [NUM_CORES-1:0] capture;
  logic [NUM_CORES-1:0] flag;
  logic [31:0]          h0_cap [NUM_CORES];
  logic                 all_done, last_write, dispatch_w;

  // base_q is stable from DISPATCH through the last WRITE, so the current
  // batch geometry can be derived from it combinationally.
  always_comb begin
    batch_w = batch_size({16'd0, base_q}, 32'(NUM_NONCES), 32'(NUM_CORES));
    for (int i = 0; i < NUM_CORES; i++) begin
      started_mask[i] = (32'(i) < batch_w);
    end
  end

  assign dispatch_w  = (state_q == ST_DISPATCH);
  assign all_done    = &(flag | ~started_mask);
  assign last_write  = (32'(wr_idx_q) == (batch_w - 32'd1));
  assign next_base_w = {16'd0, base_q} + batch_w;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign capture[i] = (state_q == ST_WAIT) && started_mask[i] && core_done[i];

    core_result_latch u_latch (
      .clk     (clk),
      .reset   (reset),
      .clear   (dispatch_w),
      .capture (capture[i]),
      .h0_in   (core_h0[i*32 +: 32]),
      .flag    (flag[i]),
      .h0      (h0_cap[i])
    );
  end

  // NOTE: combinational next-state logic uses blocking '=', the register block
  // below uses non-blocking '<=' so all flops update together at the edge.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    addr_d       = addr_q;
    wr_idx_d     = wr_idx_q;
    core_start_d = '0;
    core_nonce_d = core_nonce_q;
    next_batch_w = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = output_addr;
          base_d  = '0;
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        wr_idx_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (all_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_write) begin
          wr_idx_d = '0;
          base_d   = next_base_w[15:0];
          state_d  = (next_base_w < 32'(NUM_NONCES)) ? ST_DISPATCH : ST_DONE;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start pulses and nonces are registered on the way into DISPATCH so they
    // are presented during the DISPATCH cycle and held until the next one.
    if (state_d == ST_DISPATCH) begin
      next_batch_w = batch_size({16'd0, base_d}, 32'(NUM_NONCES), 32'(NUM_CORES));
      for (int i = 0; i < NUM_CORES; i++) begin
        if (32'(i) < next_batch_w) begin
          core_start_d[i]          = 1'b1;
          core_nonce_d[i*32 +: 32] = {16'd0, base_d} + 32'(i);
        end else begin
          core_nonce_d[i*32 +: 32] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      wr_idx_q     <= '0;
      core_start_q <= '0;
      core_nonce_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      wr_idx_q     <= wr_idx_d;
      core_start_q <= core_start_d;
      core_nonce_q <= core_nonce_d;
    end
  end

  assign done           = (state_q == ST_DONE);
  assign core_start     = core_start_q;
  assign core_nonce     = core_nonce_q;
  assign mem_clk        = clk;
  assign mem_we         = (state_q == ST_WRITE);
  assign mem_addr       = mem_we ? (addr_q + base_q + 16'(wr_idx_q)) : 16'd0;
  assign mem_write_data = mem_we ? h0_cap[wr_idx_q] : 32'd0;

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Self-checking bench for nonce_dispatch_ctrl: three instances (16, 6 and 4 nonces
// on 4 cores), behavioural cores, and a write scoreboard filled at job start.
module tb_nonce_dispatch_ctrl;

  localparam int NC   = 4;
  localparam int NDUT = 3;
  localparam int NNS [NDUT] = '{16, 6, 4};
  localparam logic [31:0] H0_KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic             start  [NDUT];
  logic [15:0]      oaddr  [NDUT];
  logic             done   [NDUT];
  logic [NC-1:0]    cstart [NDUT];
  logic [NC*32-1:0] cnonce [NDUT];
  logic [NC-1:0]    cdone  [NDUT];
  logic [NC*32-1:0] ch0    [NDUT];
  logic             mclk   [NDUT];
  logic             mwe    [NDUT];
  logic [15:0]      maddr  [NDUT];
  logic [31:0]      mwd    [NDUT];

  int            dly  [NDUT][NC];
  logic [NC-1:0] spur [NDUT];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nonce_dispatch_ctrl #(.NUM_NONCES(16), .NUM_CORES(NC)) u_dut16 (
    .clk(clk), .reset(reset), .start(start[0]), .output_addr(oaddr[0]), .done(done[0]),
    .core_start(cstart[0]), .core_nonce(cnonce[0]), .core_done(cdone[0]), .core_h0(ch0[0]),
    .mem_clk(mclk[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_write_data(mwd[0]));

  nonce_dispatch_ctrl #(.NUM_NONCES(6), .NUM_CORES(NC)) u_dut6 (
    .clk(clk), .reset(reset), .start(start[1]), .output_addr(oaddr[1]), .done(done[1]),
    .core_start(cstart[1]), .core_nonce(cnonce[1]), .core_done(cdone[1]), .core_h0(ch0[1]),
    .mem_clk(mclk[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_write_data(mwd[1]));

  nonce_dispatch_ctrl #(.NUM_NONCES(4), .NUM_CORES(NC)) u_dut4 (
    .clk(clk), .reset(reset), .start(start[2]), .output_addr(oaddr[2]), .done(done[2]),
    .core_start(cstart[2]), .core_nonce(cnonce[2]), .core_done(cdone[2]), .core_h0(ch0[2]),
    .mem_clk(mclk[2]), .mem_we(mwe[2]), .mem_addr(maddr[2]), .mem_write_data(mwd[2]));

  // Behavioural cores: answer dly cycles after seeing core_start with nonce^key.
  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    for (genvar i = 0; i < NC; i++) begin : g_core
      int          cnt     = 0;
      logic        done_r  = 1'b0;
      logic [31:0] nonce_r = '0;
      logic [31:0] h_r     = '0;
      always @(posedge clk) begin
        done_r <= 1'b0;
        if (cstart[d][i]) begin
          cnt     <= dly[d][i];
          nonce_r <= cnonce[d][i*32 +: 32];
        end else if (cnt > 0) begin
          cnt <= cnt - 1;
          if (cnt == 1) begin
            done_r <= 1'b1;
            h_r    <= nonce_r ^ H0_KEY;
          end
        end
      end
      assign cdone[d][i]         = done_r | spur[d][i];
      assign ch0[d][i*32 +: 32]  = h_r;
    end
  end

  typedef struct {
    int          dut;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          dut;
    logic [15:0] addr;
    int          d0, d1, d2, d3;
    int          min_lat;
    int          exp_writes;
  } vec_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  epoch = 0;
  int  start_cyc = 0;
  int  job_w0 = 0;
  int  wr_cnt     [NDUT] = '{0, 0, 0};
  int  first_disp [NDUT] = '{0, 0, 0};
  int  first_wr   [NDUT] = '{0, 0, 0};
  int  disp_ep    [NDUT] = '{-1, -1, -1};
  int  wr_ep      [NDUT] = '{-1, -1, -1};
  int  nbase      [NDUT] = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observes dispatches and writes away from the active edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (cstart[d] != '0) begin
          int            exp_b;
          logic [NC-1:0] m;
          if (disp_ep[d] != epoch) begin
            disp_ep[d]    = epoch;
            first_disp[d] = cyc;
            nbase[d]      = 0;
          end
          exp_b = NNS[d] - nbase[d];
          if (exp_b > NC) exp_b = NC;
          if (exp_b < 0)  exp_b = 0;
          m = '0;
          for (int i = 0; i < exp_b; i++) m[i] = 1'b1;
          check("dispatch_mask", 32'(cstart[d]), 32'(m));
          for (int i = 0; i < exp_b; i++)
            check("dispatch_nonce", cnonce[d][i*32 +: 32], 32'(nbase[d] + i));
          nbase[d] += exp_b;
        end
        if (mwe[d]) begin
          wr_cnt[d]++;
          if (wr_ep[d] != epoch) begin
            wr_ep[d]    = epoch;
            first_wr[d] = cyc;
          end
          if (sb.size() == 0) begin
            check("unexpected_write_we", 32'(mwe[d]), 32'd0);
          end else begin
            wr_t e;
            e = sb.pop_front();
            check("write_dut",  32'(d), 32'(e.dut));
            check("write_addr", 32'(maddr[d]), 32'(e.addr));
            check("write_data", mwd[d], e.data);
          end
        end
      end
    end
  endtask

  task automatic begin_job(input int d, input logic [15:0] addr);
    epoch++;
    for (int n = 0; n < NNS[d]; n++) begin
      wr_t e;
      e.dut  = d;
      e.addr = addr + 16'(n);
      e.data = 32'(n) ^ H0_KEY;
      sb.push_back(e);
    end
    job_w0 = wr_cnt[d];
    @(negedge clk);
    start[d]  = 1'b1;
    oaddr[d]  = addr;
    start_cyc = cyc;
    @(negedge clk);
    start[d] = 1'b0;
    oaddr[d] = 16'h1234;
  endtask

  task automatic finish_job(input int d, input int exp_writes);
    int k;
    k = 0;
    while (!done[d] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(done[d]), 32'd1);
    check("write_count", 32'(wr_cnt[d] - job_w0), 32'(exp_writes));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("start_to_dispatch", 32'(first_disp[d] - start_cyc), 32'd1);
    sb.delete();
  endtask

  task automatic set_dly(input int d, input int a, input int b, input int c, input int e);
    dly[d][0] = a; dly[d][1] = b; dly[d][2] = c; dly[d][3] = e;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 16'd2000,  10, 10, 10, 10, 10, 16};  // full 16-nonce job
    vecs[1] = '{1, 16'd2000,  10, 10, 10, 10, 10,  6};  // partial final batch
    vecs[2] = '{2, 16'hFFFE,   3,  3,  3,  3,  3,  4};  // address wrap
    vecs[3] = '{0, 16'd2000,   1,  1,  1,  1,  3, 16};  // immediate cores, restart from DONE
    vecs[4] = '{0, 16'd100,   40, 20, 20,  5, 40, 16};  // out-of-order completion

    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0;
      oaddr[d] = '0;
      spur[d]  = '0;
      set_dly(d, 1, 1, 1, 1);
    end
    fork
      monitor();
    join_none

    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_done",       32'(done[d]),   32'd0);
      check("rst_core_start", 32'(cstart[d]), 32'd0);
      check("rst_core_nonce", 32'(cnonce[d] != '0), 32'd0);
      check("rst_mem_we",     32'(mwe[d]),    32'd0);
      check("rst_mem_addr",   32'(maddr[d]),  32'd0);
      check("rst_mem_data",   mwd[d],         32'd0);
    end
    check("mem_clk_low", 32'(mclk[0]), 32'(clk));
    @(posedge clk); #1;
    check("mem_clk_high", 32'(mclk[0]), 32'(clk));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Spurious core_done while idle must do nothing.
    spur[2] = '1;
    @(negedge clk);
    spur[2] = '0;
    repeat (10) @(negedge clk);
    check("idle_spur_done",   32'(done[2]),   32'd0);
    check("idle_spur_start",  32'(cstart[2]), 32'd0);
    check("idle_spur_writes", 32'(wr_cnt[2]), 32'd0);

    for (int v = 0; v < 5; v++) begin
      set_dly(vecs[v].dut, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
      begin_job(vecs[v].dut, vecs[v].addr);
      finish_job(vecs[v].dut, vecs[v].exp_writes);
      check("dispatch_to_first_write_min",
            32'((first_wr[vecs[v].dut] - first_disp[vecs[v].dut]) >= vecs[v].min_lat), 32'd1);
      repeat (5) @(negedge clk);
      check("done_holds", 32'(done[vecs[v].dut]), 32'd1);
    end

    // start pulsed while waiting on the cores is ignored.
    set_dly(1, 20, 20, 20, 20);
    begin_job(1, 16'd2000);
    repeat (6) @(negedge clk);
    start[1] = 1'b1;
    oaddr[1] = 16'd500;
    @(negedge clk);
    start[1] = 1'b0;
    finish_job(1, 6);
    repeat (30) @(negedge clk);
    check("wait_start_no_rerun", 32'(wr_cnt[1] - job_w0), 32'd6);
    check("wait_start_done", 32'(done[1]), 32'd1);

    // Reset in the middle of a write burst, then a clean full job.
    set_dly(0, 10, 10, 10, 10);
    begin_job(0, 16'd2000);
    begin
      int k;
      k = 0;
      while ((wr_cnt[0] - job_w0) < 2 && k < 3000) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("mid_write_count", 32'(wr_cnt[0] - job_w0), 32'd2);
    check("mid_write_active", 32'(mwe[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_mem_we",   32'(mwe[0]),   32'd0);
    check("rst_mid_mem_addr", 32'(maddr[0]), 32'd0);
    check("rst_mid_done",     32'(done[0]),  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_mid_no_more_writes", 32'(wr_cnt[0] - job_w0), 32'd2);
    check("rst_mid_idle_done",      32'(done[0]),   32'd0);
    check("rst_mid_no_dispatch",    32'(cstart[0]), 32'd0);
    sb.delete();
    begin_job(0, 16'd2000);
    finish_job(0, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
